// File: rtl/aes_req_scheduler.sv
// aes_req_scheduler: round-robin front end that time-shares one single-shot
// AES core among NUM_REQ requesters. Each granted job restarts the core, then
// waits for done or a watchdog timeout. The result goes back tagged with the
// requester id.
module aes_req_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [128*NUM_REQ-1:0]   req_din,
  input  logic [128*NUM_REQ-1:0]   req_key,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [127:0]             rsp_dout,
  output logic                     rsp_err,
  output logic                     core_rst,
  output logic [127:0]             core_din,
  output logic [127:0]             core_keyin,
  input  logic [127:0]             core_dout,
  input  logic                     core_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]         r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_id;
  logic [15:0]        r_wdog;
  logic [127:0]       r_core_din;
  logic [127:0]       r_core_key;
  logic [127:0]       r_rsp_dout;
  logic               r_rsp_err;

  logic               w_any;
  logic [ID_W-1:0]    w_gnt;
  logic [ID_W-1:0]    w_idx;
  int unsigned        w_sum;
  logic [NUM_REQ-1:0] w_ready;
  logic [15:0]        w_wdog_inc;
  logic               w_grant;

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = '0;
    w_sum = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_sum = int'(r_ptr) + k;
      if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
      w_idx = ID_W'(w_sum);
      if (!w_any && req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  // The grant pulse is combinational, so it appears in the same IDLE cycle
  // that latches the data. It is gated by rst_n so it stays low during reset.
  assign w_grant = rst_n && (r_state == S_IDLE) && w_any;

  // One-hot accept strobe towards the granted requester.
  always_comb begin
    w_ready = '0;
    if (w_grant) w_ready[w_gnt] = 1'b1;
  end

  // The watchdog counts the current RUN cycle as well. An abort therefore
  // leaves RUN after exactly TIMEOUT cycles, and the count never passes TIMEOUT.
  assign w_wdog_inc = r_wdog + 16'd1;

  // Main controller: grant, load, run with watchdog, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_id       <= '0;
      r_wdog     <= '0;
      r_core_din <= '0;
      r_core_key <= '0;
      r_rsp_dout <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wdog <= '0;
          if (w_any) begin
            r_core_din <= req_din[128*w_gnt +: 128];
            r_core_key <= req_key[128*w_gnt +: 128];
            r_id       <= w_gnt;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: r_state <= S_RUN;
        S_RUN: begin
          r_wdog <= w_wdog_inc;
          if (core_done) begin
            r_rsp_dout <= core_dout;
            r_rsp_err  <= 1'b0;
            r_state    <= S_RESP;
          end else if (w_wdog_inc == 16'(TIMEOUT)) begin
            r_rsp_dout <= '0;
            r_rsp_err  <= 1'b1;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_ptr   <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
            r_wdog  <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = w_ready;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_id;
  assign rsp_dout   = r_rsp_dout;
  assign rsp_err    = r_rsp_err;
  assign core_rst   = (r_state != S_RUN);
  assign core_din   = r_core_din;
  assign core_keyin = r_core_key;

endmodule
